mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single RAM port (MAR load, RAM enable, MFC wait, MDR capture) and shares it between two requesters: instruction fetch (IF) and data load/store (D).
- Replaces hand-coded MAR/RAM/MDR steps in control states with a request/done handshake.
- Sits between the control unit and the MAR/RAM/MDR datapath; owns MAR_Enable, RAM_enable, RAM_OpCode and MDR_Enable.

Parameters:
- TIMEOUT_CYCLES, 16: max ACCESS cycles without MFC before error (only with MEM_TIMEOUT_EN); legal 2..255.
- FETCH_OP, 6'b000000: RAM_OpCode driven for IF accesses (load word).

Ports:
- Clk  input  1  system clock, rising edge.
- RESET  input  1  synchronous active-low reset, sampled on Clk rising edge; 0 = reset.
- if_req  input  1  fetch request; held until if_done.
- if_addr  input  32  fetch address (PC).
- if_gnt  output  1  IF owns port (GRANT through DONE).
- if_done  output  1  one-cycle pulse, fetch data in MDR.
- d_req  input  1  data request; held until d_done.
- d_addr  input  32  effective address (ALU out).
- d_op  input  6  load/store opcode, IR[24:19].
- d_gnt  output  1  D owns port.
- d_done  output  1  one-cycle pulse, access complete.
- MAR_addr  output  32  address muxed to MAR input.
- MAR_Enable  output  1  MAR load.
- RAM_enable  output  1  RAM strobe.
- RAM_OpCode  output  6  RAM operation.
- MDR_Enable  output  1  MDR load from RAM.
- MFC  input  1  memory function complete.
- busy  output  1  state != IDLE.
- mem_err  output  1  timeout pulse (constant 0 without MEM_TIMEOUT_EN).

Behaviour:
- Reset (RESET=0 at edge): state IDLE, every output 0, MAR_addr=0, RAM_OpCode=0, rr_last=IF, timeout counter 0; applies from any state, including mid-ACCESS (abandoned access, no done pulse).
- States: IDLE -> GRANT -> ACCESS -> CAPTURE -> DONE -> IDLE; with MEM_TIMEOUT_EN, ACCESS -> ERR -> IDLE.
- IDLE: sample requests. Only one asserted -> that owner. Both asserted -> owner is the one not equal to rr_last (round-robin; first tie after reset goes to D). None -> stay. Owner and its address/opcode registered at transition.
- GRANT (1 cycle): owner gnt=1, MAR_addr=registered address, MAR_Enable=1, RAM_OpCode = FETCH_OP for IF or d_op for D.
- ACCESS: MAR_Enable=0, RAM_enable=1; stay while MFC=0; MFC=1 -> CAPTURE.
- CAPTURE (1 cycle): RAM_enable=0; MDR_Enable=1 for IF and for D when d_op[2]=0 (load); 0 for stores (d_op[2]=1).
- DONE (1 cycle): owner done=1, gnt still 1; rr_last <= owner; -> IDLE.
- RAM_OpCode and MAR_addr are held stable from GRANT through DONE; both are 0 in IDLE.
- Latency: request seen in IDLE at edge N -> GRANT N+1, ACCESS N+2; MFC high at edge M -> CAPTURE M+1, done M+2. Minimum 5 cycles request-to-done. The earliest IDLE regrant is at M+3.
- Request deasserted before grant: ignored. Deasserted after grant: access completes and done still pulses. Address/op changes after IDLE are ignored.
- MFC high in IDLE/GRANT is ignored; only sampled in ACCESS.
- Same requester re-requesting back-to-back while the other waits: the other wins next (no starvation).

Optional Feature:
- MEM_TIMEOUT_EN defined: an 8-bit counter clears on ACCESS entry and increments each ACCESS cycle with MFC=0. Reaching TIMEOUT_CYCLES -> ERR (1 cycle): RAM_enable=0, mem_err=1, owner gnt=1, no done, no MDR_Enable; rr_last <= owner; -> IDLE.
- MEM_TIMEOUT_EN undefined: no counter, no ERR state; ACCESS waits indefinitely; mem_err tied 0.

Test Plan:
- Reset: hold RESET=0 3 cycles in mid-ACCESS -> all outputs 0, busy=0; release with both reqs high -> D granted first.
- Fetch alone: if_req=1, if_addr=0x00000004, MFC after 2 ACCESS cycles -> MAR_addr=0x4, RAM_OpCode=0, MDR_Enable one cycle, if_done one cycle, 7 cycles request-to-done.
- Store: d_req, d_addr=0x00000100, d_op=6'b000100 -> RAM_OpCode=0x04, MDR_Enable never 1, d_done pulse.
- Contention: both reqs held continuously -> grants alternate D,IF,D,IF over 4 accesses; never both gnt high.
- Late drop: d_req dropped in ACCESS -> access still completes, d_done pulses; MFC pulse in IDLE causes no action.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, MFC held 0 -> mem_err pulse after 4 ACCESS cycles, no done, return to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle: IF and D requester handshakes plus the MAR/RAM/MDR strobes.
// The arbiter takes the slave modport; the control unit / datapath side takes master.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_done;
   logic        d_req;
   logic [31:0] d_addr;
   logic [5:0]  d_op;
   logic        d_gnt;
   logic        d_done;
   logic [31:0] MAR_addr;
   logic        MAR_Enable;
   logic        RAM_enable;
   logic [5:0]  RAM_OpCode;
   logic        MDR_Enable;
   logic        MFC;
   logic        busy;
   logic        mem_err;

   modport master (
      output if_req, if_addr, d_req, d_addr, d_op, MFC,
      input  if_gnt, if_done, d_gnt, d_done, MAR_addr, MAR_Enable,
             RAM_enable, RAM_OpCode, MDR_Enable, busy, mem_err
   );

   modport slave (
      input  if_req, if_addr, d_req, d_addr, d_op, MFC,
      output if_gnt, if_done, d_gnt, d_done, MAR_addr, MAR_Enable,
             RAM_enable, RAM_OpCode, MDR_Enable, busy, mem_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin IF/D sharing of the single RAM port: GRANT, ACCESS (until MFC), CAPTURE, DONE; min 5 cycles req->done.
// Requesters hold req until done; MEM_TIMEOUT_EN adds an ACCESS watchdog that ends in a one-cycle ERR.
module mem_port_arbiter #(
   parameter int         TIMEOUT_CYCLES = 16,
   parameter logic [5:0] FETCH_OP       = 6'b000000
) (
   input logic               Clk,
   input logic               RESET,
   mem_port_arbiter_if.slave bus
);

   generate
      if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be within 2..255");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, GRANT, ACCESS, CAPTURE, DONE, ERR} state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   state_t state;
   logic   owner;
   logic   rr_last;
   logic   pick_d;

   // On a tie the requester that was not served last wins.
   assign pick_d   = bus.d_req && (!bus.if_req || rr_last == OWN_IF);
   assign bus.busy = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
   logic [7:0] to_cnt;
   logic       err_q;
   assign bus.mem_err = err_q;
`else
   assign bus.mem_err = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (!RESET) begin
         state          <= IDLE;
         owner          <= OWN_IF;
         rr_last        <= OWN_IF;
         bus.if_gnt     <= 1'b0;
         bus.if_done    <= 1'b0;
         bus.d_gnt      <= 1'b0;
         bus.d_done     <= 1'b0;
         bus.MAR_addr   <= '0;
         bus.MAR_Enable <= 1'b0;
         bus.RAM_enable <= 1'b0;
         bus.RAM_OpCode <= '0;
         bus.MDR_Enable <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         to_cnt         <= '0;
         err_q          <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.if_req || bus.d_req) begin
                  state          <= GRANT;
                  owner          <= pick_d;
                  bus.if_gnt     <= !pick_d;
                  bus.d_gnt      <= pick_d;
                  bus.MAR_addr   <= pick_d ? bus.d_addr : bus.if_addr;
                  bus.RAM_OpCode <= pick_d ? bus.d_op : FETCH_OP;
                  bus.MAR_Enable <= 1'b1;
               end
            end
            GRANT: begin
               state          <= ACCESS;
               bus.MAR_Enable <= 1'b0;
               bus.RAM_enable <= 1'b1;
`ifdef MEM_TIMEOUT_EN
               to_cnt         <= '0;
`endif
            end
            ACCESS: begin
               if (bus.MFC) begin
                  state          <= CAPTURE;
                  bus.RAM_enable <= 1'b0;
                  // Stores (op bit 2 set) leave MDR untouched; fetches always load.
                  bus.MDR_Enable <= (owner == OWN_IF) || !bus.RAM_OpCode[2];
               end
`ifdef MEM_TIMEOUT_EN
               else if (to_cnt == TIMEOUT_LIM - 8'd1) begin
                  state          <= ERR;
                  to_cnt         <= to_cnt + 8'd1;
                  bus.RAM_enable <= 1'b0;
                  err_q          <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
`endif
            end
            CAPTURE: begin
               state          <= DONE;
               bus.MDR_Enable <= 1'b0;
               bus.if_done    <= (owner == OWN_IF);
               bus.d_done     <= (owner == OWN_D);
            end
            DONE, ERR: begin
               state          <= IDLE;
               rr_last        <= owner;
               bus.if_gnt     <= 1'b0;
               bus.d_gnt      <= 1'b0;
               bus.if_done    <= 1'b0;
               bus.d_done     <= 1'b0;
               bus.MAR_addr   <= '0;
               bus.RAM_OpCode <= '0;
`ifdef MEM_TIMEOUT_EN
               err_q          <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model (round-robin owner, latency, MDR use).
module tb_mem_port_arbiter;
`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif
   localparam logic [5:0] FOP  = 6'b000000;
   localparam int         KMAX = (TO - 1 < 4) ? TO - 1 : 4;

   logic clk;
   logic rst_n;
   mem_port_arbiter_if bus();

   mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .FETCH_OP(FOP)) dut (
      .Clk   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   logic [46:0] outs;
   assign outs = {bus.if_gnt, bus.if_done, bus.d_gnt, bus.d_done, bus.MAR_addr,
                  bus.MAR_Enable, bus.RAM_enable, bus.RAM_OpCode, bus.MDR_Enable,
                  bus.busy, bus.mem_err};

   // Model state: 1 when D was the last requester served.
   bit m_rr_d;

   bit          ob_own_d;
   logic [31:0] ob_addr;
   logic [5:0]  ob_op;
   int          ob_done_cyc, ob_mdr, ob_done, ob_bad, ob_err_cyc;
   bit          ob_tmo;

   function automatic bit model_pick_d(bit i_r, bit d_r, bit rr_d);
      if (i_r && d_r) return !rr_d;
      return d_r;
   endfunction

   // Runs one access from an IDLE cycle (cycle 1) and records what the port did.
   task automatic do_access(input int k_wait, input bit hold, input bit drop_acc, input bit pulse_if);
      int cyc, acc;
      bit granted, fin;
      cyc = 1; acc = 0; granted = 0; fin = 0;
      ob_own_d = 0; ob_addr = '0; ob_op = '0;
      ob_done_cyc = 0; ob_mdr = 0; ob_done = 0; ob_bad = 0; ob_err_cyc = 0;
      bus.MFC = 1'b0;
      for (int t = 0; t < 100 && !fin; t++) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (bus.if_gnt && bus.d_gnt) ob_bad++;
         if (bus.MAR_Enable && !granted) begin
            granted  = 1;
            ob_own_d = bus.d_gnt;
            ob_addr  = bus.MAR_addr;
            ob_op    = bus.RAM_OpCode;
            if (!(bus.if_gnt || bus.d_gnt)) ob_bad++;
         end else if (granted && bus.busy &&
                      (bus.MAR_addr !== ob_addr || bus.RAM_OpCode !== ob_op || bus.MAR_Enable)) begin
            ob_bad++;
         end
         if (bus.MDR_Enable) ob_mdr++;
         if (ob_own_d ? bus.if_done : bus.d_done) ob_bad++;
         if (ob_own_d ? bus.d_done : bus.if_done) begin
            ob_done++;
            ob_done_cyc = cyc;
         end
         if (bus.mem_err) ob_err_cyc = cyc;
         if (granted && !bus.busy) begin
            fin = 1;
         end else begin
            if (bus.RAM_enable) begin
               acc++;
               if (acc == 1) begin
                  bus.if_addr = $urandom;
                  bus.d_addr  = $urandom;
                  bus.d_op    = 6'($urandom);
                  if (drop_acc) begin
                     if (ob_own_d) bus.d_req = 1'b0;
                     else bus.if_req = 1'b0;
                  end
                  if (pulse_if) bus.if_req = 1'b1;
               end
               if (acc == 2 && pulse_if) bus.if_req = 1'b0;
               bus.MFC = (k_wait >= 0 && acc > k_wait);
            end else begin
               bus.MFC = 1'b0;
            end
            if (!hold && (ob_done != 0 || ob_err_cyc != 0)) begin
               if (ob_own_d) bus.d_req = 1'b0;
               else bus.if_req = 1'b0;
            end
         end
      end
      ob_tmo = !fin;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outs: got %h expected 0", outs);
      end
      rst_n  = 1'b1;
      m_rr_d = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got %h expected 0", outs);
      end
   endtask

   task automatic test_fetch();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0004;
      do_access(2, 0, 0, 0);
      checks++;
      if (ob_tmo || ob_own_d !== 1'b0) begin
         errors++;
         $display("FAIL fetch_owner: got d=%0d tmo=%0d expected IF", ob_own_d, ob_tmo);
      end
      checks++;
      if (ob_addr !== 32'h4 || ob_op !== FOP) begin
         errors++;
         $display("FAIL fetch_mar: got addr=%h op=%h expected 4/%h", ob_addr, ob_op, FOP);
      end
      checks++;
      if (ob_mdr !== 1 || ob_done !== 1) begin
         errors++;
         $display("FAIL fetch_pulses: got mdr=%0d done=%0d expected 1/1", ob_mdr, ob_done);
      end
      checks++;
      if (ob_done_cyc !== 7) begin
         errors++;
         $display("FAIL fetch_latency: got %0d expected 7", ob_done_cyc);
      end
      checks++;
      if (ob_bad !== 0) begin
         errors++;
         $display("FAIL fetch_protocol: got %0d violations expected 0", ob_bad);
      end
      m_rr_d = 1'b0;
   endtask

   task automatic test_store();
      int k;
      k = $urandom_range(0, KMAX);
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h0000_0100;
      bus.d_op   = 6'b000100;
      do_access(k, 0, 0, 0);
      checks++;
      if (ob_tmo || ob_own_d !== 1'b1 || ob_addr !== 32'h100 || ob_op !== 6'h04) begin
         errors++;
         $display("FAIL store_grant: got d=%0d addr=%h op=%h expected 1/100/04", ob_own_d, ob_addr, ob_op);
      end
      checks++;
      if (ob_mdr !== 0 || ob_done !== 1 || ob_done_cyc !== 5 + k) begin
         errors++;
         $display("FAIL store_done: got mdr=%0d done=%0d cyc=%0d expected 0/1/%0d", ob_mdr, ob_done, ob_done_cyc, 5 + k);
      end
      m_rr_d = 1'b1;
   endtask

   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         int          r, k;
         bit          e_d;
         logic [31:0] e_addr;
         logic [5:0]  e_op;
         r = $urandom_range(1, 3);
         k = $urandom_range(0, KMAX);
         bus.if_req  = r[0];
         bus.d_req   = r[1];
         bus.if_addr = $urandom;
         bus.d_addr  = $urandom;
         bus.d_op    = 6'($urandom);
         e_d    = model_pick_d(r[0], r[1], m_rr_d);
         e_addr = e_d ? bus.d_addr : bus.if_addr;
         e_op   = e_d ? bus.d_op : FOP;
         do_access(k, 0, 0, 0);
         checks++;
         if (ob_tmo || ob_own_d !== e_d || ob_addr !== e_addr || ob_op !== e_op) begin
            errors++;
            $display("FAIL rand%0d_grant: got d=%0d addr=%h op=%h expected d=%0d addr=%h op=%h",
                     it, ob_own_d, ob_addr, ob_op, e_d, e_addr, e_op);
         end
         checks++;
         if (ob_mdr !== ((!e_d || !e_op[2]) ? 1 : 0) || ob_done !== 1 || ob_done_cyc !== 5 + k) begin
            errors++;
            $display("FAIL rand%0d_done: got mdr=%0d done=%0d cyc=%0d expected mdr=%0d done=1 cyc=%0d",
                     it, ob_mdr, ob_done, ob_done_cyc, (!e_d || !e_op[2]) ? 1 : 0, 5 + k);
         end
         checks++;
         if (ob_bad !== 0 || ob_err_cyc !== 0) begin
            errors++;
            $display("FAIL rand%0d_protocol: got bad=%0d err_cyc=%0d expected 0/0", it, ob_bad, ob_err_cyc);
         end
         m_rr_d = e_d;
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
   endtask

   task automatic test_late_drop();
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h0000_0200;
      bus.d_op   = 6'b100011;
      do_access(3, 0, 1, 1);
      checks++;
      if (ob_tmo || ob_own_d !== 1'b1 || ob_done !== 1 || ob_mdr !== 1 || ob_done_cyc !== 8) begin
         errors++;
         $display("FAIL late_drop: got d=%0d done=%0d mdr=%0d cyc=%0d expected 1/1/1/8",
                  ob_own_d, ob_done, ob_mdr, ob_done_cyc);
      end
      m_rr_d = 1'b1;
      for (int c = 0; c < 4; c++) begin
         bus.MFC = (c < 2);
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL idle_ignore%0d: got %h expected 0", c, outs);
         end
      end
      bus.MFC = 1'b0;
   endtask

   task automatic test_wait();
`ifdef MEM_TIMEOUT_EN
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0300;
      do_access(-1, 0, 0, 0);
      checks++;
      if (ob_tmo || ob_own_d !== 1'b0 || ob_err_cyc !== 3 + TO) begin
         errors++;
         $display("FAIL timeout_err: got d=%0d err_cyc=%0d tmo=%0d expected 0/%0d/0", ob_own_d, ob_err_cyc, ob_tmo, 3 + TO);
      end
      checks++;
      if (ob_done !== 0 || ob_mdr !== 0 || ob_bad !== 0) begin
         errors++;
         $display("FAIL timeout_quiet: got done=%0d mdr=%0d bad=%0d expected 0/0/0", ob_done, ob_mdr, ob_bad);
      end
      m_rr_d = 1'b0;
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      do_access(0, 0, 0, 0);
      checks++;
      if (ob_tmo || ob_own_d !== model_pick_d(1'b1, 1'b1, m_rr_d) || ob_done !== 1) begin
         errors++;
         $display("FAIL after_timeout_rr: got d=%0d done=%0d expected d=%0d done=1",
                  ob_own_d, ob_done, model_pick_d(1'b1, 1'b1, m_rr_d));
      end
      m_rr_d = model_pick_d(1'b1, 1'b1, m_rr_d);
`else
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0300;
      do_access(20, 0, 0, 0);
      checks++;
      if (ob_tmo || ob_done !== 1 || ob_done_cyc !== 25 || ob_err_cyc !== 0) begin
         errors++;
         $display("FAIL long_wait: got done=%0d cyc=%0d err_cyc=%0d tmo=%0d expected 1/25/0/0",
                  ob_done, ob_done_cyc, ob_err_cyc, ob_tmo);
      end
      m_rr_d = 1'b0;
`endif
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen = 0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0040;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk);
         @(negedge clk);
         seen = bus.RAM_enable;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL reach_access: got no RAM_enable within 10 cycles expected ACCESS");
      end
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL mid_reset%0d: got %h expected 0", c, outs);
         end
      end
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h0000_0500;
      bus.d_op   = 6'b000001;
      m_rr_d     = 1'b0;
      rst_n      = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         bit          e_d;
         logic [31:0] e_addr;
         e_d    = model_pick_d(bus.if_req, bus.d_req, m_rr_d);
         e_addr = e_d ? bus.d_addr : bus.if_addr;
         do_access($urandom_range(0, KMAX), 1, 0, 0);
         checks++;
         if (ob_tmo || ob_own_d !== e_d || ob_addr !== e_addr || ob_done !== 1 || ob_bad !== 0) begin
            errors++;
            $display("FAIL b2b%0d: got d=%0d addr=%h done=%0d bad=%0d expected d=%0d addr=%h done=1 bad=0",
                     i, ob_own_d, ob_addr, ob_done, ob_bad, e_d, e_addr);
         end
         m_rr_d = e_d;
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
   endtask

   initial begin
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_addr  = '0;
      bus.d_op    = '0;
      bus.MFC     = 1'b0;
      rst_n       = 1'b0;
      test_reset();
      test_fetch();
      test_store();
      test_random();
      test_late_drop();
      test_wait();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
